blockram_port_arbiter: RTL and testbench

//  Shares one request/response port of a block RAM (or RTLReg-style resource) between NumClients requesters.

---
 rtl/blockram_port_arbiter_pkg.sv | 15 +
 rtl/blockram_port_arbiter_tag_fifo.sv | 68 ++++++
 rtl/blockram_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_blockram_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blockram_port_arbiter_pkg.sv
// Shared sizing helpers for the block RAM port arbiter and its tag FIFO.
// The request word is laid out as {addr, data, wr}, with wr in bit 0.
package blockram_port_arbiter_pkg;

    // Width of one request word: {addr, data, wr}.
    function automatic int unsigned req_w(input int unsigned width, input int unsigned addr_width);
        return width + addr_width + 1;
    endfunction

    // Pointer width for a FIFO of the given depth; a one-entry FIFO still needs a 1-bit pointer.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/blockram_port_arbiter_tag_fifo.sv
// In-order tag FIFO holding the client id of every request in flight to memory.
// Ports: clk, resetn (async active-low); push/din write a tag; pop/dout read the head;
// full, empty and count (0..Depth) report occupancy.
module blockram_port_arbiter_tag_fifo
    import blockram_port_arbiter_pkg::*;
#(
    parameter  int unsigned Width = 2,
    parameter  int unsigned Depth = 4,
    localparam int unsigned PtrW  = ptr_w(Depth),
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            push,
    input  logic [Width-1:0] din,
    input  logic            pop,
    output logic [Width-1:0] dout,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    logic [Width-1:0] tags [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = tags[rd_ptr];

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            tags[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/blockram_port_arbiter.sv
// Shares one valid/bp request/response port of a block RAM between NumClients requesters.
// Round-robin grant that locks onto a stalled client until it is accepted; an in-order tag
// FIFO routes each memory response back to the client that issued it. Zero-latency
// memories are handled by routing a same-cycle response straight to the issuing client.
// Ports: clk, resetn (async active-low); client_req/_valid/_bp per-client requests;
// client_resp/_valid/_bp per-client responses; mem_req/_valid/_bp and mem_resp/_valid/_bp
// towards the memory port.
module blockram_port_arbiter
    import blockram_port_arbiter_pkg::*;
#(
    parameter  int unsigned Width          = 8,
    parameter  int unsigned AddrWidth      = 8,
    parameter  int unsigned NumClients     = 4,
    parameter  int unsigned ClientIdWidth  = 2,
    parameter  int unsigned MaxOutstanding = 4,
    localparam int unsigned ReqW           = req_w(Width, AddrWidth)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NumClients*ReqW-1:0] client_req,
    input  logic [NumClients-1:0]      client_req_valid,
    output logic [NumClients-1:0]      client_req_bp,
    output logic [NumClients*Width-1:0] client_resp,
    output logic [NumClients-1:0]      client_resp_valid,
    input  logic [NumClients-1:0]      client_resp_bp,
    output logic [ReqW-1:0]            mem_req,
    output logic                       mem_req_valid,
    input  logic                       mem_req_bp,
    input  logic [Width-1:0]           mem_resp,
    input  logic                       mem_resp_valid,
    output logic                       mem_resp_bp
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [ClientIdWidth-1:0] rr_ptr;
    logic [ClientIdWidth-1:0] locked_id;
    logic                     lock;
    logic [ClientIdWidth-1:0] grant;
    logic                     found;
    int unsigned              idx;
    logic                     cand_valid;
    logic [ReqW-1:0]          req_slice [NumClients];

    logic [ClientIdWidth-1:0] head_id;
    logic [ClientIdWidth-1:0] route_id;
    logic                     route_ok;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CntW-1:0]          fifo_count;
    logic                     head_pop;
    logic                     full_eff;
    logic                     accept;
    logic                     resp_fire;
    logic                     push_wr;
    logic                     pop_rd;

    for (genvar i = 0; i < NumClients; i++) begin : g_slice
        assign req_slice[i] = client_req[i*ReqW +: ReqW];
    end

    // Round-robin search starting at rr_ptr; a stalled client keeps the grant.
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NumClients; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NumClients) begin
                idx = idx - NumClients;
            end
            if (!found && client_req_valid[ClientIdWidth'(idx)]) begin
                found = 1'b1;
                grant = ClientIdWidth'(idx);
            end
        end
        if (lock) begin
            grant = locked_id;
        end
    end

    assign cand_valid = lock ? client_req_valid[locked_id] : |client_req_valid;

    // A full FIFO whose head drains this cycle can still take a new tag. Only the head path
    // is considered: a full FIFO is never empty, so the bypass path cannot apply.
    assign head_pop = resetn && !fifo_empty && mem_resp_valid && !client_resp_bp[head_id];
    assign full_eff = fifo_full && !head_pop;

    assign mem_req       = req_slice[grant];
    assign mem_req_valid = resetn && cand_valid && !full_eff;
    assign accept        = mem_req_valid && !mem_req_bp;

    // Only the granted client can see its request taken.
    always_comb begin
        client_req_bp = '1;
        if (resetn) begin
            client_req_bp[grant] = mem_req_bp || full_eff;
        end
    end

    // Response goes to the oldest tag, or to the client being accepted right now when the
    // FIFO is empty (zero-latency memory).
    always_comb begin
        route_ok = 1'b0;
        route_id = head_id;
        if (!fifo_empty) begin
            route_ok = 1'b1;
        end else if (accept) begin
            route_ok = 1'b1;
            route_id = grant;
        end
    end

    always_comb begin
        client_resp_valid = '0;
        if (resetn && route_ok) begin
            client_resp_valid[route_id] = mem_resp_valid;
        end
    end

    // Untagged responses are swallowed rather than stalling memory.
    assign mem_resp_bp = !resetn ? 1'b1 : (route_ok ? client_resp_bp[route_id] : 1'b0);
    assign client_resp = {NumClients{mem_resp}};

    assign resp_fire = mem_resp_valid && route_ok && !mem_resp_bp;
    assign pop_rd    = resp_fire && !fifo_empty;
    // A bypassed tag is consumed immediately and never written.
    assign push_wr   = accept && !(fifo_empty && resp_fire);

    // Round-robin pointer and stall lock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr    <= '0;
            lock      <= 1'b0;
            locked_id <= '0;
        end else if (mem_req_valid) begin
            if (!mem_req_bp) begin
                rr_ptr <= (grant == ClientIdWidth'(NumClients - 1)) ? '0 : grant + ClientIdWidth'(1);
                lock   <= 1'b0;
            end else begin
                lock      <= 1'b1;
                locked_id <= grant;
            end
        end
    end

    blockram_port_arbiter_tag_fifo #(
        .Width (ClientIdWidth),
        .Depth (MaxOutstanding)
    ) u_tag_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_wr),
        .din    (grant),
        .pop    (pop_rd),
        .dout   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Memory must never answer a request that was not issued.
    a_resp_has_tag: assert property (@(posedge clk) disable iff (!resetn) mem_resp_valid |-> route_ok);
    a_count_bound:  assert property (@(posedge clk) disable iff (!resetn) fifo_count <= CntW'(MaxOutstanding));

endmodule

// File: tb/tb_blockram_port_arbiter.sv
// Scoreboard bench for blockram_port_arbiter with a 0- or 3-cycle latency memory model.
module tb_blockram_port_arbiter;

    localparam int unsigned W   = 8;
    localparam int unsigned AW  = 8;
    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned MO  = 4;
    localparam int unsigned RW  = W + AW + 1;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N*RW-1:0]   client_req;
    logic [N-1:0]      client_req_valid;
    logic [N-1:0]      client_req_bp;
    logic [N*W-1:0]    client_resp;
    logic [N-1:0]      client_resp_valid;
    logic [N-1:0]      client_resp_bp;
    logic [RW-1:0]     mem_req;
    logic              mem_req_valid;
    logic              mem_req_bp;
    logic [W-1:0]      mem_resp;
    logic              mem_resp_valid;
    logic              mem_resp_bp;

    always #5 clk = ~clk;

    blockram_port_arbiter #(
        .Width          (W),
        .AddrWidth      (AW),
        .NumClients     (N),
        .ClientIdWidth  (IDW),
        .MaxOutstanding (MO)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .client_req        (client_req),
        .client_req_valid  (client_req_valid),
        .client_req_bp     (client_req_bp),
        .client_resp       (client_resp),
        .client_resp_valid (client_resp_valid),
        .client_resp_bp    (client_resp_bp),
        .mem_req           (mem_req),
        .mem_req_valid     (mem_req_valid),
        .mem_req_bp        (mem_req_bp),
        .mem_resp          (mem_resp),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_bp       (mem_resp_bp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model (environment) ----------------
    int unsigned     lat;
    bit [W-1:0]      mem_arr [256];
    logic [W-1:0]    rq_data [16];
    longint unsigned rq_due  [16];
    int unsigned     rq_head = 0;
    int unsigned     rq_tail = 0;
    longint unsigned cyc = 0;

    always_comb begin
        mem_resp_valid = 1'b0;
        mem_resp       = '0;
        if (resetn) begin
            if (rq_tail != rq_head) begin
                if (rq_due[rq_head % 16] <= cyc) begin
                    mem_resp_valid = 1'b1;
                    mem_resp       = rq_data[rq_head % 16];
                end
            end else if (lat == 0 && mem_req_valid && !mem_req_bp) begin
                mem_resp_valid = 1'b1;
                mem_resp       = mem_req[0] ? mem_req[8:1] : mem_arr[mem_req[16:9]];
            end
        end
    end

    always @(posedge clk) begin
        automatic bit acc_m  = mem_req_valid && !mem_req_bp;
        automatic bit bypass = (rq_tail == rq_head) && (lat == 0) && acc_m;
        automatic bit fire   = mem_resp_valid && !mem_resp_bp;
        if (!resetn) begin
            rq_head <= 0;
            rq_tail <= 0;
        end else begin
            if (fire && rq_tail != rq_head) begin
                rq_head <= rq_head + 1;
            end
            if (acc_m && !(bypass && fire)) begin
                rq_data[rq_tail % 16] <= mem_req[0] ? mem_req[8:1] : mem_arr[mem_req[16:9]];
                rq_due[rq_tail % 16]  <= cyc + lat;
                rq_tail <= rq_tail + 1;
            end
            if (acc_m && mem_req[0]) begin
                mem_arr[mem_req[16:9]] = mem_req[8:1];
            end
        end
        cyc <= cyc + 1;
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int         id;
        logic [W-1:0] data;
    } exp_t;

    exp_t        sb [$];
    int unsigned m_rr = 0;
    bit          m_lock = 1'b0;
    int unsigned m_locked = 0;
    bit [W-1:0]  ref_mem [256];
    bit [W-1:0]  last_resp [N];

    // Issue side: predict grant/valid/bp from the arbitration rules, push expected responses.
    always @(negedge clk) begin
        automatic bit          cand = 1'b0;
        automatic int unsigned g = 0;
        automatic bit          pop_exp;
        automatic bit          full_eff;
        automatic bit          exp_v;
        automatic logic [N-1:0] exp_bp;
        automatic logic [RW-1:0] pl;
        automatic exp_t        e;
        if (!resetn) begin
            chk("rst_req_bp", client_req_bp, {N{1'b1}});
            chk("rst_mem_req_valid", mem_req_valid, 1'b0);
            chk("rst_resp_valid", client_resp_valid, '0);
            chk("rst_mem_resp_bp", mem_resp_bp, 1'b1);
            sb.delete();
            m_rr   = 0;
            m_lock = 1'b0;
        end else begin
            if (m_lock) begin
                g    = m_locked;
                cand = client_req_valid[g];
            end else begin
                g = m_rr;
                for (int k = 0; k < N; k++) begin
                    automatic int unsigned i = (m_rr + k) % N;
                    if (!cand && client_req_valid[i]) begin
                        cand = 1'b1;
                        g    = i;
                    end
                end
            end
            pop_exp  = mem_resp_valid && (sb.size() > 0) && !client_resp_bp[sb[0].id];
            full_eff = (sb.size() >= MO) && !pop_exp;
            exp_v    = cand && !full_eff;
            chk("mem_req_valid", mem_req_valid, exp_v);
            exp_bp    = '1;
            exp_bp[g] = mem_req_bp || full_eff;
            chk("client_req_bp", client_req_bp, exp_bp);
            if (exp_v) begin
                pl = client_req[g*RW +: RW];
                chk("mem_req_mux", mem_req, pl);
                if (!mem_req_bp) begin
                    e.id   = int'(g);
                    e.data = pl[0] ? pl[8:1] : ref_mem[pl[16:9]];
                    if (pl[0]) begin
                        ref_mem[pl[16:9]] = pl[8:1];
                    end
                    sb.push_back(e);
                    m_rr   = (g + 1) % N;
                    m_lock = 1'b0;
                end else begin
                    m_lock   = 1'b1;
                    m_locked = g;
                end
            end
        end
    end

    // Response side: whenever memory answers, the oldest expected tag must receive it.
    always @(negedge clk) begin
        automatic exp_t e;
        #1;
        if (resetn) begin
            if (mem_resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_orphan: got response %0h with no outstanding request at %0t",
                             mem_resp, $time);
                end else begin
                    e = sb[0];
                    chk("resp_valid_route", client_resp_valid, N'(1) << e.id);
                    chk("mem_resp_bp", mem_resp_bp, client_resp_bp[e.id]);
                    chk("resp_data", client_resp[e.id*W +: W], e.data);
                    if (!client_resp_bp[e.id]) begin
                        last_resp[e.id] = client_resp[e.id*W +: W];
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("resp_idle", client_resp_valid, '0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] acc;

    // Clients keep valid/payload until accepted, then may issue a fresh request.
    task automatic step(input int unsigned pv, input int unsigned ps, input int unsigned prb);
        @(negedge clk);
        acc = client_req_valid & ~client_req_bp;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!client_req_valid[i] || acc[i]) begin
                if ($urandom_range(0, 99) < pv) begin
                    client_req_valid[i]     = 1'b1;
                    client_req[i*RW +: RW] = {8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom)};
                end else begin
                    client_req_valid[i] = 1'b0;
                end
            end
            client_resp_bp[i] = ($urandom_range(0, 99) < prb);
        end
        mem_req_bp = ($urandom_range(0, 99) < ps);
    endtask

    task automatic drain();
        int c = 0;
        while (c < 200 && (client_req_valid != '0 || sb.size() != 0 || rq_tail != rq_head)) begin
            step(0, 0, 0);
            c++;
        end
        checks++;
        if (client_req_valid != '0 || sb.size() != 0 || rq_tail != rq_head) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses still outstanding after %0d cycles", sb.size(), c);
        end
    endtask

    task automatic send(input int id, input logic [RW-1:0] p);
        bit done = 1'b0;
        @(posedge clk);
        #1;
        client_req_valid[id]     = 1'b1;
        client_req[id*RW +: RW] = p;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = client_req_valid[id] && !client_req_bp[id];
        end
        @(posedge clk);
        #1;
        client_req_valid[id] = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: client %0d request not accepted", id);
        end
    endtask

    initial begin
        resetn           = 1'b0;
        lat              = 0;
        mem_req_bp       = 1'b0;
        client_resp_bp   = '0;
        client_req_valid = '1;
        for (int i = 0; i < N; i++) begin
            client_req[i*RW +: RW] = {8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom)};
        end
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("first_grant_client0", client_req_bp[0], 1'b0);

        // Saturated, no backpressure: strict rotation, zero-latency responses.
        repeat (40) step(100, 0, 0);
        // Random stalls (lock) and response backpressure.
        repeat (300) step(50, 30, 20);
        drain();

        // Pipelined memory: FIFO fills and issues on pop cycles.
        lat = 3;
        repeat (300) step(70, 10, 20);
        repeat (10) step(100, 0, 0);

        // Reset in the middle of a burst with requests in flight.
        resetn           = 1'b0;
        client_req_valid = '1;
        mem_req_bp       = 1'b0;
        client_resp_bp   = '0;
        repeat (2) @(posedge clk);
        #1;
        lat    = 0;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_grant0", client_req_bp[0], 1'b0);
        repeat (150) step(60, 20, 20);
        drain();

        // Write then read of the same address by different clients.
        send(1, {8'h05, 8'hA5, 1'b1});
        send(2, {8'h05, 8'h00, 1'b0});
        drain();
        chk("write_resp_client1", last_resp[1], 8'hA5);
        chk("read_after_write_client2", last_resp[2], 8'hA5);

        lat = 3;
        repeat (200) step(80, 10, 30);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
